ex_muldiv: RTL and testbench

Parametrised iterative multiply/divide unit that sits beside the EX-stage ALU and executes MULT, MULTU, DIV and DIVU over multiple cycles. While an operation is in flight it holds the pipeline through `stallreq`, then writes the 2×WIDTH-bit result into HI/LO. `annul` lets a flush abandon an operation mid-flight.

---
 rtl/ex_muldiv.sv | 197 +++++++++++++++++++
 tb/tb_ex_muldiv.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv.sv
// rtl/ex_muldiv.sv - iterative multiply/divide unit for the EX stage
//
// Executes MULT, MULTU, DIV and DIVU over WIDTH+2 cycles and writes the
// 2*WIDTH-bit result into HI/LO.
//
// Ports:
//   clk       clock, rising edge
//   rst       synchronous active-high reset
//   start     operation request, held by EX while the instruction sits there
//   op        00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   src1      multiplicand / dividend
//   src2      multiplier / divisor
//   annul     abandon the current operation (flush)
//   stallreq  combinational pipeline stall request
//   busy      registered, high while not idle
//   done      registered one-cycle pulse, hi/lo valid
//   hi        product high half or remainder
//   lo        product low half or quotient
module ex_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic             annul,
  output logic             stallreq,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10
  } state_t;

  state_t state, state_next;

  logic             is_div;
  logic             neg1;
  logic             neg2;
  logic             dbz;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] mag1;
  logic [WIDTH-1:0] mag2;
  // Multiply: running product. Divide: low half shifts dividend out and
  // quotient bits in.
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH:0]     rem;

  // Operand conditioning at issue; only signed ops take magnitudes.
  logic             sgn1_in;
  logic             sgn2_in;
  logic [WIDTH-1:0] abs1_in;
  logic [WIDTH-1:0] abs2_in;

  assign sgn1_in = ~op[0] & src1[WIDTH-1];
  assign sgn2_in = ~op[0] & src2[WIDTH-1];
  assign abs1_in = sgn1_in ? -src1 : src1;
  assign abs2_in = sgn2_in ? -src2 : src2;

  // Shift-add step: add multiplicand to the upper half when the current
  // multiplier bit (acc[0]) is set, then shift the whole product right.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] acc_mul_next;

  assign mul_sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? mag1 : {WIDTH{1'b0}})};
  assign acc_mul_next = {mul_sum, acc[WIDTH-1:1]};

  // Restoring step: shift in the next dividend bit and subtract the divisor
  // with one extra bit so a negative result (borrow) means "does not fit".
  logic [WIDTH+1:0] div_shift;
  logic [WIDTH+1:0] div_diff;
  logic             div_fits;

  assign div_shift = {rem, acc[WIDTH-1]};
  assign div_diff  = div_shift - {2'b00, mag2};
  assign div_fits  = ~div_diff[WIDTH+1];

  // Sign correction for the FIX edge.
  logic               sign_diff;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH-1:0]   raw1;

  assign sign_diff = neg1 ^ neg2;
  assign prod_fix  = sign_diff ? -acc : acc;
  assign quot_fix  = sign_diff ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem_fix   = neg1 ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
  assign raw1      = neg1 ? -mag1 : mag1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next != IDLE);
    end
  end

  // A start still high during the done cycle belongs to the instruction
  // just completed, so it is neither stalled on nor accepted.
  always_comb begin
    state_next = state;
    stallreq   = 1'b0;
    case (state)
      IDLE: begin
        if (start && !done) begin
          stallreq   = 1'b1;
          state_next = CALC;
        end
      end
      CALC: begin
        stallreq = 1'b1;
        if (cnt == LAST) state_next = FIX;
      end
      FIX: begin
        stallreq   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (annul) begin
      state_next = IDLE;
      stallreq   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      is_div <= 1'b0;
      neg1   <= 1'b0;
      neg2   <= 1'b0;
      dbz    <= 1'b0;
      cnt    <= '0;
      mag1   <= '0;
      mag2   <= '0;
      acc    <= '0;
      rem    <= '0;
    end else begin
      done <= 1'b0;
      if (!annul) begin
        case (state)
          IDLE: begin
            if (start && !done) begin
              is_div <= op[1];
              neg1   <= sgn1_in;
              neg2   <= sgn2_in;
              dbz    <= op[1] & (src2 == '0);
              cnt    <= '0;
              mag1   <= abs1_in;
              mag2   <= abs2_in;
              rem    <= '0;
              acc    <= {{WIDTH{1'b0}}, (op[1] ? abs1_in : abs2_in)};
            end
          end
          CALC: begin
            cnt <= cnt + CW'(1);
            if (is_div) begin
              rem            <= div_fits ? div_diff[WIDTH:0] : div_shift[WIDTH:0];
              acc[WIDTH-1:0] <= {acc[WIDTH-2:0], div_fits};
            end else begin
              acc <= acc_mul_next;
            end
          end
          FIX: begin
            done <= 1'b1;
            if (dbz) begin
              lo <= '1;
              hi <= raw1;
            end else if (is_div) begin
              lo <= quot_fix;
              hi <= rem_fix;
            end else begin
              {hi, lo} <= prod_fix;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// tb/tb_ex_muldiv.sv - self-checking bench for ex_muldiv (WIDTH=32)
module tb_ex_muldiv;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src1;
  logic [31:0] src2;
  logic        annul;
  logic        stallreq;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  always #5 clk = ~clk;

  ex_muldiv #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .src1     (src1),
    .src2     (src2),
    .annul    (annul),
    .stallreq (stallreq),
    .busy     (busy),
    .done     (done),
    .hi       (hi),
    .lo       (lo)
  );

  int          n_cmp = 0;
  int          n_fail = 0;
  logic        mon_en = 1'b0;
  logic        pending = 1'b0;
  logic [63:0] exp_res = '0;
  logic [63:0] held = '0;
  logic [63:0] last_res = '0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Reference: {hi, lo} straight from the arithmetic definition of each op.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa;
    longint sb;
    longint q;
    longint r;
    logic [63:0] ua;
    logic [63:0] ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    case (o)
      2'd0: return 64'(sa * sb);
      2'd1: return ua * ub;
      default: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        if (o == 2'd2) begin
          if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
          q = sa / sb;
          r = sa % sb;
          return {r[31:0], q[31:0]};
        end
        return {a % b, a / b};
      end
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Result checker: every cycle outside reset, hi/lo either hold the last
  // result or, on a done pulse, carry the pending expected result.
  always @(negedge clk) begin
    if (mon_en && rst !== 1'b1) begin
      if (done) begin
        check("done_expected", {63'h0, pending}, 64'h1);
        if (pending) begin
          check("result", {hi, lo}, exp_res);
          held    = exp_res;
          pending = 1'b0;
        end
      end else begin
        check("hold", {hi, lo}, held);
      end
    end
  end

  // One operation with start held through the done cycle; operands are
  // scrambled while in flight.
  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    int stall_cnt;
    int lat;
    stall_cnt = 0;
    lat = -1;
    @(posedge clk); #1;
    start   = 1'b1;
    op      = o;
    src1    = a;
    src2    = b;
    exp_res = model(o, a, b);
    pending = 1'b1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (stallreq) stall_cnt++;
      if (done) begin
        lat = k;
        break;
      end
      @(posedge clk); #1;
      src1 = $urandom;
      src2 = $urandom;
      op   = 2'($urandom);
    end
    check("latency", 64'(lat), 64'd34);
    check("stall_cycles", 64'(stall_cnt), 64'd34);
    check("stallreq_in_done", {63'h0, stallreq}, 64'h0);
    last_res = {hi, lo};
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("no_restart_busy", {63'h0, busy}, 64'h0);
    check("single_done", {63'h0, done}, 64'h0);
  endtask

  task automatic lit(input string name, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] eh, input logic [31:0] el);
    check({"model_", name}, model(o, a, b), {eh, el});
    do_op(o, a, b);
    check(name, last_res, {eh, el});
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; annul = 1'b0; op = 2'd0; src1 = '0; src2 = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_outputs", {hi, lo}, 64'h0);
    check("reset_flags", {61'h0, busy, done, stallreq}, 64'h0);
    mon_en = 1'b1;

    lit("mult_neg", 2'd0, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    lit("multu_max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    lit("div_neg", 2'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    lit("divu_100_7", 2'd3, 32'd100, 32'd7, 32'h0000_0002, 32'h0000_000E);
    lit("div_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
    lit("divu_zero", 2'd3, 32'h0000_1234, 32'h0, 32'h0000_1234, 32'hFFFF_FFFF);
    lit("div_zero_neg", 2'd2, 32'hFFFF_FFF9, 32'h0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);

    // Annul at cycle 10 of a DIV.
    @(posedge clk); #1;
    start = 1'b1; op = 2'd2; src1 = 32'd1000; src2 = 32'd3;
    pending = 1'b0;
    repeat (10) @(posedge clk);
    #1 annul = 1'b1; start = 1'b0;
    @(negedge clk);
    check("annul_stallreq", {63'h0, stallreq}, 64'h0);
    check("annul_busy_before", {63'h0, busy}, 64'h1);
    @(posedge clk); #1 annul = 1'b0;
    @(negedge clk);
    check("annul_busy_after", {63'h0, busy}, 64'h0);
    repeat (40) @(negedge clk);
    lit("mult_after_annul", 2'd0, 32'd3, 32'd4, 32'h0, 32'h0000_000C);

    // Reset mid-CALC.
    @(posedge clk); #1;
    start = 1'b1; op = 2'd1; src1 = 32'h1234_5678; src2 = 32'h9ABC_DEF0;
    pending = 1'b0;
    repeat (15) @(posedge clk);
    #1 rst = 1'b1; start = 1'b0; held = '0;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("midcalc_reset_hilo", {hi, lo}, 64'h0);
    check("midcalc_reset_flags", {61'h0, busy, done, stallreq}, 64'h0);

    for (int i = 0; i < 30; i++) begin
      do_op(2'($urandom), pick(), pick());
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
